// File: rtl/sft_seq_arb_if.sv
// Requester and shift-engine bundle for sft_seq_arb.
// The slave modport is the arbiter's view; master is the requester/engine side.
interface sft_seq_arb_if #(
    parameter int NREQ = 4
);
    // requester side
    logic [NREQ-1:0]   req_i;
    logic [NREQ-1:0]   req_clr_i;
    logic [NREQ-1:0]   req_oen_i;
    logic [8*NREQ-1:0] req_data_i;
    logic [NREQ-1:0]   grant_o;
    logic [NREQ-1:0]   ack_o;
    logic [NREQ-1:0]   err_o;
    logic              busy_o;
    // shift engine side
    logic              sft_vld;
    logic [1:0]        sft_cmd;
    logic              sft_cmd_oen;
    logic [7:0]        sft_din;
    logic              sft_done;

    modport slave (
        input  req_i, req_clr_i, req_oen_i, req_data_i, sft_done,
        output grant_o, ack_o, err_o, busy_o,
        output sft_vld, sft_cmd, sft_cmd_oen, sft_din
    );

    modport master (
        output req_i, req_clr_i, req_oen_i, req_data_i, sft_done,
        input  grant_o, ack_o, err_o, busy_o,
        input  sft_vld, sft_cmd, sft_cmd_oen, sft_din
    );
endinterface

// File: rtl/sft_seq_arb.sv
// Round-robin arbiter that shares one 595-style shift engine between NREQ
// requesters. A grant runs the fixed sequence [clr] -> shift -> latch -> OE,
// waiting for sft_done after each command with a per-command timeout.
module sft_seq_arb #(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 1024,
    parameter int TMO_W   = 11
) (
    input  logic         CLK_I,
    input  logic         RST_I,
    sft_seq_arb_if.slave bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] CMD_CLR = 2'b00;
    localparam logic [1:0] CMD_SFT = 2'b01;
    localparam logic [1:0] CMD_STO = 2'b10;
    localparam logic [1:0] CMD_OE  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, I_CLR, W_CLR, I_SFT, W_SFT, I_STO, W_STO, I_OE, W_OE, FIN, ABORT
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic              oen_q, oen_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic              vld_q, vld_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              cmd_oen_q, cmd_oen_d;
    logic [7:0]        din_q, din_d;

    logic              win_vld;
    logic [PTR_W-1:0]  win_idx;

    // Index p+off folded back into 0..NREQ-1 (off never exceeds NREQ).
    function automatic logic [PTR_W-1:0] rr_wrap(input logic [PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NREQ) s = s - NREQ;
        return PTR_W'(s);
    endfunction

    // Winner search: first requester above the last winner, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!win_vld && bus.req_i[rr_wrap(ptr_q, i)]) begin
                win_vld = 1'b1;
                win_idx = rr_wrap(ptr_q, i);
            end
        end
    end

    // Sequencer next state, grant latch and timeout counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        oen_d   = oen_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    ptr_d   = win_idx;
                    data_d  = bus.req_data_i[int'(win_idx)*8 +: 8];
                    oen_d   = bus.req_oen_i[win_idx];
                    state_d = bus.req_clr_i[win_idx] ? I_CLR : I_SFT;
                end
            end
            // issue cycles ignore sft_done: nothing is outstanding yet
            I_CLR: begin cnt_d = TMO_W'(TMO_CYC); state_d = W_CLR; end
            I_SFT: begin cnt_d = TMO_W'(TMO_CYC); state_d = W_SFT; end
            I_STO: begin cnt_d = TMO_W'(TMO_CYC); state_d = W_STO; end
            I_OE:  begin cnt_d = TMO_W'(TMO_CYC); state_d = W_OE;  end
            W_CLR, W_SFT, W_STO, W_OE: begin
                // done wins over an expired counter in the same cycle
                if (bus.sft_done) begin
                    case (state_q)
                        W_CLR:   state_d = I_SFT;
                        W_SFT:   state_d = I_STO;
                        W_STO:   state_d = I_OE;
                        default: state_d = FIN;
                    endcase
                end else if (cnt_q == '0) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q - TMO_W'(1);
                end
            end
            FIN, ABORT: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // every output leaves a flop.
    always_comb begin
        vld_d     = 1'b0;
        cmd_d     = CMD_CLR;
        cmd_oen_d = 1'b0;
        din_d     = '0;
        case (state_d)
            I_CLR:   begin vld_d = 1'b1; cmd_d = CMD_CLR; end
            I_SFT:   begin vld_d = 1'b1; cmd_d = CMD_SFT; end
            I_STO:   begin vld_d = 1'b1; cmd_d = CMD_STO; end
            I_OE:    begin vld_d = 1'b1; cmd_d = CMD_OE;  cmd_oen_d = oen_d; end
            default: ;
        endcase
        if (vld_d) din_d = data_d;

        grant_d = grant_q;
        if (state_q == IDLE && win_vld) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
        end
        if (state_d == IDLE) grant_d = '0;

        ack_d  = (state_d == FIN)   ? grant_d : '0;
        err_d  = (state_d == ABORT) ? grant_d : '0;
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any in-flight command.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_W'(NREQ - 1);
            cnt_q     <= '0;
            data_q    <= '0;
            oen_q     <= 1'b0;
            grant_q   <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            vld_q     <= 1'b0;
            cmd_q     <= '0;
            cmd_oen_q <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            oen_q     <= oen_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            vld_q     <= vld_d;
            cmd_q     <= cmd_d;
            cmd_oen_q <= cmd_oen_d;
            din_q     <= din_d;
        end
    end

    assign bus.grant_o     = grant_q;
    assign bus.ack_o       = ack_q;
    assign bus.err_o       = err_q;
    assign bus.busy_o      = busy_q;
    assign bus.sft_vld     = vld_q;
    assign bus.sft_cmd     = cmd_q;
    assign bus.sft_cmd_oen = cmd_oen_q;
    assign bus.sft_din     = din_q;

endmodule

// File: tb/tb_sft_seq_arb.sv
// Bench for sft_seq_arb: directed table of single-requester transactions,
// hand sequences for round-robin order and mid-sequence reset, then random
// traffic checked cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_sft_seq_arb;
    localparam int NREQ  = 4;
    localparam int TMO   = 8;
    localparam int TMO_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sft_seq_arb_if #(.NREQ(NREQ)) bus ();

    sft_seq_arb #(.NREQ(NREQ), .TMO_CYC(TMO), .TMO_W(TMO_W)) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // engine behaviour: 0 = random delay, >0 fixed delay, -1 never answers
    int eng_mode = 1;
    int eng_tgt  = -1;

    // model: phase of the current transaction plus its remaining command list
    typedef enum int {P_IDLE, P_SERVE, P_FIN, P_ABORT} phase_e;
    phase_e     m_ph   = P_IDLE;
    int         m_ptr  = NREQ - 1;
    int         m_win  = 0;
    int         m_vcyc = 0;
    int         m_cmds[$];
    logic [7:0] m_data = '0;
    logic       m_oen  = 1'b0;

    // statistics for the directed parts
    int              n_vld = 0;
    int              first_vld = 0;
    int              end_cyc = 0;
    logic [NREQ-1:0] ack_seen = '0;
    logic [NREQ-1:0] err_seen = '0;
    int              gq[$];
    logic [NREQ-1:0] gprev = '0;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 1; i <= NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // Monitor + model + engine, once per cycle at the falling edge. Inputs
    // seen here are the ones the DUT sampled at the edge just passed.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg, ea, ee;
        logic            eb, ev, eo, ao;
        logic [1:0]      ec, ac;
        logic [7:0]      ed, ad;
        int              pk, dly, gidx;

        cyc++;
        if (rst) begin
            m_ph  = P_IDLE;
            m_ptr = NREQ - 1;
            m_cmds.delete();
        end else begin
            case (m_ph)
                P_IDLE: begin
                    pk = rr_pick(bus.req_i, m_ptr);
                    if (pk >= 0) begin
                        m_win  = pk;
                        m_ptr  = pk;
                        m_data = bus.req_data_i[8*pk +: 8];
                        m_oen  = bus.req_oen_i[pk];
                        m_cmds.delete();
                        if (bus.req_clr_i[pk]) m_cmds.push_back(0);
                        m_cmds.push_back(1);
                        m_cmds.push_back(2);
                        m_cmds.push_back(3);
                        m_ph   = P_SERVE;
                        m_vcyc = cyc;
                    end
                end
                P_SERVE: begin
                    if (bus.sft_done && (cyc - 1 > m_vcyc)) begin
                        void'(m_cmds.pop_front());
                        if (m_cmds.size() == 0) m_ph = P_FIN;
                        else m_vcyc = cyc;
                    end else if (cyc - 1 == m_vcyc + TMO + 1) begin
                        m_ph = P_ABORT;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end

        eg = '0;
        if (m_ph != P_IDLE) eg[m_win] = 1'b1;
        ea = (m_ph == P_FIN)   ? eg : '0;
        ee = (m_ph == P_ABORT) ? eg : '0;
        eb = (m_ph != P_IDLE);
        ev = (m_ph == P_SERVE) && (m_vcyc == cyc);
        ec = '0; eo = 1'b0; ed = '0;
        if (ev) begin
            ec = 2'(m_cmds[0]);
            ed = m_data;
            eo = (m_cmds[0] == 3) ? m_oen : 1'b0;
        end
        ac = bus.sft_cmd; ao = bus.sft_cmd_oen; ad = bus.sft_din;
        if (!ev) begin ac = '0; ao = 1'b0; ad = '0; end
        check($sformatf("cycle%0d", cyc),
              {bus.grant_o, bus.ack_o, bus.err_o, bus.busy_o, bus.sft_vld, ac, ao, ad},
              {eg, ea, ee, eb, ev, ec, eo, ed});

        // statistics
        if (bus.sft_vld) begin
            if (n_vld == 0) first_vld = cyc;
            n_vld++;
        end
        if ((bus.ack_o | bus.err_o) != '0) end_cyc = cyc;
        ack_seen |= bus.ack_o;
        err_seen |= bus.err_o;
        if (bus.grant_o != '0 && gprev == '0) begin
            gidx = 0;
            for (int k = 0; k < NREQ; k++) if (bus.grant_o[k]) gidx = k;
            gq.push_back(gidx);
        end
        gprev = bus.grant_o;

        // shift engine model
        if (rst) begin
            eng_tgt = -1;
        end else if (bus.sft_vld) begin
            if (eng_mode == 0) begin
                case ($urandom_range(0, 19))
                    0:       dly = -1;
                    1:       dly = TMO + 1;
                    default: dly = int'($urandom_range(1, 4));
                endcase
            end else begin
                dly = eng_mode;
            end
            eng_tgt = (dly < 0) ? -1 : cyc + dly;
        end
        bus.sft_done = (eng_tgt >= 0) && (cyc == eng_tgt);
        if (bus.sft_done) eng_tgt = -1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_stats();
        n_vld = 0; first_vld = 0; end_cyc = 0;
        ack_seen = '0; err_seen = '0;
        gq.delete();
    endtask

    typedef struct {
        int              idx;
        logic            clr;
        logic            oen;
        logic [7:0]      data;
        int              dly;
        int              nvld;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
        int              len;   // cycles from first vld to ack/err
    } vec_t;

    vec_t tbl[6];
    int   rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        int w;
        int re[NREQ];

        bus.req_i = '0; bus.req_clr_i = '0; bus.req_oen_i = '0; bus.req_data_i = '0;
        tbl[0] = '{1, 1'b0, 1'b0, 8'hA5, 2,       3, 4'b0010, 4'b0000, 9};
        tbl[1] = '{0, 1'b1, 1'b1, 8'h3C, 1,       4, 4'b0001, 4'b0000, 8};
        tbl[2] = '{2, 1'b0, 1'b1, 8'h5A, -1,      1, 4'b0000, 4'b0100, TMO + 2};
        tbl[3] = '{3, 1'b0, 1'b0, 8'hC3, TMO + 1, 3, 4'b1000, 4'b0000, 3 * (TMO + 2)};
        tbl[4] = '{1, 1'b1, 1'b0, 8'h0F, TMO + 2, 1, 4'b0000, 4'b0010, TMO + 2};
        tbl[5] = '{0, 1'b0, 1'b1, 8'hFF, 3,       3, 4'b0001, 4'b0000, 12};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_out", {bus.grant_o, bus.ack_o, bus.err_o, bus.busy_o, bus.sft_vld}, '0);

        // directed single-requester transactions
        for (int r = 0; r < 6; r++) begin
            clr_stats();
            eng_mode = tbl[r].dly;
            bus.req_clr_i[tbl[r].idx] = tbl[r].clr;
            bus.req_oen_i[tbl[r].idx] = tbl[r].oen;
            bus.req_data_i[8*tbl[r].idx +: 8] = tbl[r].data;
            bus.req_i[tbl[r].idx] = 1'b1;
            w = 0;
            while ((bus.ack_o | bus.err_o) == '0 && w < 200) begin tick(); w++; end
            check($sformatf("row%0d_end", r), (w < 200), 1);
            // data change after grant must not matter
            bus.req_data_i[8*tbl[r].idx +: 8] = ~tbl[r].data;
            bus.req_i[tbl[r].idx] = 1'b0;
            tick(); tick();
            check($sformatf("row%0d_ack", r), ack_seen, tbl[r].ack);
            check($sformatf("row%0d_err", r), err_seen, tbl[r].err);
            check($sformatf("row%0d_nvld", r), n_vld, tbl[r].nvld);
            check($sformatf("row%0d_len", r), end_cyc - first_vld, tbl[r].len);
            check($sformatf("row%0d_idle", r), bus.busy_o, 0);
        end

        // round-robin fairness with all requesters held
        rst = 1'b1; tick(); rst = 1'b0; tick();
        clr_stats();
        eng_mode = 1;
        bus.req_clr_i = '0;
        for (int k = 0; k < NREQ; k++) re[k] = 0;
        bus.req_i = '1;
        w = 0;
        while (gq.size() < 6 && w < 400) begin
            tick(); w++;
            for (int k = 0; k < NREQ; k++) begin
                if (bus.ack_o[k]) begin
                    bus.req_i[k] = 1'b0; re[k] = 2;
                end else if (re[k] > 0) begin
                    re[k]--;
                    if (re[k] == 0) bus.req_i[k] = 1'b1;
                end
            end
        end
        check("rr_count", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            check($sformatf("rr_grant%0d", i), gq[i], rr_exp[i]);
        bus.req_i = '0;
        w = 0;
        while (bus.busy_o && w < 200) begin tick(); w++; end
        check("rr_drain", bus.busy_o, 0);
        tick();

        // reset while waiting for the latch command to finish
        clr_stats();
        eng_mode = 3;
        bus.req_data_i[15:8] = 8'h77;
        bus.req_i[1] = 1'b1;
        w = 0;
        while (n_vld < 2 && w < 100) begin tick(); w++; end
        check("rst_reach_sto", n_vld, 2);
        tick();
        rst = 1'b1; bus.req_i = '0;
        tick();
        rst = 1'b0;
        check("rst_mid", {bus.grant_o, bus.ack_o, bus.err_o, bus.busy_o, bus.sft_vld}, '0);
        clr_stats();
        bus.req_data_i[7:0] = 8'h11; bus.req_data_i[31:24] = 8'h33;
        bus.req_i = 4'b1001;
        w = 0;
        while (bus.grant_o == '0 && w < 20) begin tick(); w++; end
        check("rst_tie_grant", bus.grant_o, 4'b0001);
        check("rst_first_cmd", {bus.sft_vld, bus.sft_cmd, bus.sft_din}, {1'b1, 2'b01, 8'h11});
        check("rst_no_pulse", {ack_seen, err_seen}, '0);
        bus.req_i = '0;
        w = 0;
        while (bus.busy_o && w < 200) begin tick(); w++; end

        // random traffic against the model
        eng_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (bus.ack_o[k] || bus.err_o[k]) begin
                    bus.req_i[k] = 1'b0;
                end else if (!bus.req_i[k] && $urandom_range(0, 7) == 0) begin
                    bus.req_i[k]     = 1'b1;
                    bus.req_clr_i[k] = 1'($urandom);
                    bus.req_oen_i[k] = 1'($urandom);
                    bus.req_data_i[8*k +: 8] = 8'($urandom);
                end else if (bus.req_i[k] && $urandom_range(0, 63) == 0) begin
                    bus.req_i[k] = 1'b0;
                end
                if ($urandom_range(0, 15) == 0) bus.req_data_i[8*k +: 8] = 8'($urandom);
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        bus.req_i = '0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
